updown_digit_counter: RTL and testbench
=======================================

Name: updown_digit_counter

Overview:
Parametrised multi-digit up/down counter with a built-in step prescaler, wrap or saturate mode, and parallel load. Each digit counts modulo MODULUS with a carry/borrow chain. A multiplexed 7-segment scanner drives one digit at a time. It sits between the top-level pin wrapper and the display pins, and replaces single-digit fixed 0–9 counters.

Parameters:
DIGITS, 2, number of digits (1..4).
MODULUS, 10, per-digit modulus (2..16). Each digit holds 0..MODULUS-1.
TICK_DIV, 1000, clk cycles per count step (>=1). 1 = step every enabled cycle.
SCAN_DIV, 4, clk cycles each digit is displayed (>=1).

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  count enable; gates the prescaler.
dir  in  1  1 = count up, 0 = count down.
sat  in  1  0 = wrap at limits, 1 = saturate at limits.
load  in  1  synchronous parallel load strobe.
load_val  in  4*DIGITS  load value, 4 bits per digit, digit 0 in bits [3:0].
value  out  4*DIGITS  current count, same packing as load_val.
wrap_pulse  out  1  one-cycle pulse on wrap-around.
seg  out  7  segments of the scanned digit, active-high, bit0=a .. bit6=g.
digit_sel  out  DIGITS  one-hot select of the scanned digit.

Behaviour:
- Reset (async, rst=1):
  - value=0, prescaler=0, wrap_pulse=0.
  - Scan counter=0, scan index=0, digit_sel=1 (digit 0), seg=7'h3F.
- Priority per cycle: rst > load > step > hold.
- Load:
  - value <= load_val, with each digit field >= MODULUS clamped to MODULUS-1.
  - Prescaler cleared to 0; no step that cycle; wrap_pulse=0 next cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1 and holds while en=0.
  - A step fires in the cycle the prescaler equals TICK_DIV-1; it then returns to 0.
  - Changing dir or sat does not clear the prescaler.
- Step up:
  - Digit 0 increments. A digit at MODULUS-1 goes to 0 and carries into the next digit.
  - Step takes effect at the same edge as the prescaler rollover, so value updates 1 cycle after the step cycle.
- Step down: mirror of step up. A digit at 0 goes to MODULUS-1 and borrows from the next digit.
- Upper limit (all digits MODULUS-1, dir=1):
  - sat=0: value -> all 0 and wrap_pulse=1 for exactly one cycle.
  - sat=1: value holds and wrap_pulse stays 0.
- Lower limit (all digits 0, dir=0):
  - sat=0: value -> all MODULUS-1 and wrap_pulse=1 for one cycle.
  - sat=1: value holds.
- wrap_pulse is registered and asserts in the cycle after the wrapping edge's step cycle, i.e. coincident with the wrapped value. It is never high for 2 consecutive cycles unless TICK_DIV=1 and wrapping repeats.
- Scanner:
  - Free-running, independent of en.
  - Scan counter runs 0..SCAN_DIV-1. On rollover the scan index advances modulo DIGITS.
  - digit_sel and seg are registered together from the new index and the current value. They change on the same edge and never disagree for even one cycle.
  - seg reflects value with at most 1 cycle of latency.
- seg encoding (hex 0..F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Arithmetic: digit fields are 4-bit unsigned; no overflow beyond MODULUS-1 is ever stored.
- rst asserted mid-step or mid-scan forces the reset values immediately, without waiting for clk.

Test Plan:
1. TICK_DIV=1, DIGITS=2, MODULUS=10, en=1, dir=1, sat=0, from reset for 100 cycles -> value steps 00,01..99,00. wrap_pulse high exactly once, in the cycle value=00 after 99.
2. Same config, load 8'h05, dir=0 -> 04,03..00,99. wrap_pulse on 99. Repeat with sat=1 -> value holds 00 and wrap_pulse stays 0.
3. TICK_DIV=4, en toggled 1,1,0,0,1,1 -> exactly one step after 4 enabled cycles. Prescaler holds during en=0.
4. load_val=8'hFA with MODULUS=10 -> value=8'h99. A load in the same cycle as a step overrides the step, and the prescaler restarts (next step after TICK_DIV cycles).
5. SCAN_DIV=2, value=8'h37 -> digit_sel alternates 01,10 every 2 cycles with seg=07 ("7") then 4F ("3").
6. Assert rst asynchronously between clk edges mid-count -> all outputs at reset values before the next edge. After release, counting resumes from 0.

Source files
------------

// File: rtl/updown_digit_counter_if.sv
// Control and display bundle for updown_digit_counter.
// master drives count controls and observes display; slave is the counter.
interface updown_digit_counter_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  en;
  logic                  dir;
  logic                  sat;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   value;
  logic                  wrap_pulse;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     digit_sel;

  modport master (
    output en, dir, sat, load, load_val,
    input  value, wrap_pulse, seg, digit_sel
  );

  modport slave (
    input  en, dir, sat, load, load_val,
    output value, wrap_pulse, seg, digit_sel
  );
endinterface

// File: rtl/updown_digit_counter.sv
// Multi-digit modulo-MODULUS up/down counter with step prescaler,
// wrap/saturate limits, parallel load and a multiplexed 7-segment scanner.
module updown_digit_counter #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned MODULUS  = 10,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  updown_digit_counter_if.slave  bus
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]  DMAX = 4'(MODULUS - 1);

  logic [VW-1:0]     r_value;
  logic              r_wrap;
  logic [PW-1:0]     r_presc;
  logic [SW-1:0]     r_scan_cnt;
  logic [IW-1:0]     r_scan_idx;
  logic [DIGITS-1:0] r_digit_sel;
  logic [6:0]        r_seg;

  logic              w_step;
  logic              w_at_max;
  logic              w_at_min;
  logic              w_limit;
  logic [VW-1:0]     w_ripple;
  logic [VW-1:0]     w_load_clamped;
  logic              w_scan_roll;
  logic [IW-1:0]     w_idx_next;
  logic [3:0]        w_scan_digit;
  logic [DIGITS-1:0] w_sel_next;

  // Hex digit to active-high segments (bit0=a .. bit6=g).
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  assign w_step  = bus.en && (r_presc == PW'(TICK_DIV - 1));
  assign w_limit = bus.dir ? w_at_max : w_at_min;

  // Carry/borrow ripple across digits plus all-max / all-zero detection.
  always_comb begin : ripple_p
    logic carry;
    carry    = 1'b1;
    w_ripple = r_value;
    w_at_max = 1'b1;
    w_at_min = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_value[4*i +: 4] != DMAX) w_at_max = 1'b0;
      if (r_value[4*i +: 4] != 4'd0) w_at_min = 1'b0;
      if (carry) begin
        if (bus.dir) begin
          if (r_value[4*i +: 4] == DMAX) begin
            w_ripple[4*i +: 4] = 4'd0;
          end else begin
            w_ripple[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (r_value[4*i +: 4] == 4'd0) begin
            w_ripple[4*i +: 4] = DMAX;
          end else begin
            w_ripple[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Clamp each loaded digit field into 0..MODULUS-1.
  always_comb begin
    w_load_clamped = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ({1'b0, bus.load_val[4*i +: 4]} >= 5'(MODULUS)) begin
        w_load_clamped[4*i +: 4] = DMAX;
      end else begin
        w_load_clamped[4*i +: 4] = bus.load_val[4*i +: 4];
      end
    end
  end

  // Step prescaler: counts enabled cycles, restarts on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (bus.load) begin
      r_presc <= '0;
    end else if (bus.en) begin
      r_presc <= w_step ? '0 : r_presc + PW'(1);
    end
  end

  // Count value and wrap pulse; saturation holds value at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_wrap  <= 1'b0;
    end else if (bus.load) begin
      r_value <= w_load_clamped;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_wrap <= w_limit && !bus.sat;
      if (!(w_limit && bus.sat)) r_value <= w_ripple;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign w_scan_roll = (r_scan_cnt == SW'(SCAN_DIV - 1));

  // Next scan index and the digit/select it implies.
  always_comb begin
    w_idx_next = r_scan_idx;
    if (w_scan_roll) begin
      w_idx_next = (r_scan_idx == IW'(DIGITS - 1)) ? '0 : r_scan_idx + IW'(1);
    end
    w_scan_digit = 4'd0;
    w_sel_next   = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_idx_next == IW'(i)) begin
        w_scan_digit  = r_value[4*i +: 4];
        w_sel_next[i] = 1'b1;
      end
    end
  end

  // Free-running scanner; select and segments always updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_scan_idx  <= '0;
      r_digit_sel <= DIGITS'(1);
      r_seg       <= 7'h3F;
    end else begin
      r_scan_cnt  <= w_scan_roll ? '0 : r_scan_cnt + SW'(1);
      r_scan_idx  <= w_idx_next;
      r_digit_sel <= w_sel_next;
      r_seg       <= seg_of(w_scan_digit);
    end
  end

  assign bus.value      = r_value;
  assign bus.wrap_pulse = r_wrap;
  assign bus.seg        = r_seg;
  assign bus.digit_sel  = r_digit_sel;

endmodule

// File: tb/tb_updown_digit_counter.sv
// Bench for updown_digit_counter: two configurations driven in lockstep,
// a count-domain reference model, vector tables and corner sequences.
module tb_updown_digit_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        t_en = 1'b0, t_dir = 1'b0, t_sat = 1'b0, t_load = 1'b0;
  logic [7:0]  t_lva = '0;
  logic [11:0] t_lvb = '0;

  always #5 clk = ~clk;

  updown_digit_counter_if #(.DIGITS(2)) ifa ();
  updown_digit_counter_if #(.DIGITS(3)) ifb ();

  assign ifa.en = t_en;   assign ifa.dir = t_dir; assign ifa.sat = t_sat;
  assign ifa.load = t_load; assign ifa.load_val = t_lva;
  assign ifb.en = t_en;   assign ifb.dir = t_dir; assign ifb.sat = t_sat;
  assign ifb.load = t_load; assign ifb.load_val = t_lvb;

  updown_digit_counter #(.DIGITS(2), .MODULUS(10), .TICK_DIV(1), .SCAN_DIV(2))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  updown_digit_counter #(.DIGITS(3), .MODULUS(6), .TICK_DIV(4), .SCAN_DIV(3))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: value as a plain integer count per unit.
  int         m_n [2];
  int         m_pre [2];
  int         m_cyc;
  logic       m_wrap [2];
  logic [3:0] m_sel [2];
  logic [6:0] m_seg [2];

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int pdig(input int u);  return (u == 0) ? 2 : 3;  endfunction
  function automatic int pmod(input int u);  return (u == 0) ? 10 : 6; endfunction
  function automatic int ptick(input int u); return (u == 0) ? 1 : 4;  endfunction
  function automatic int pscan(input int u); return (u == 0) ? 2 : 3;  endfunction

  function automatic int mpow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int digit_of(input int u, input int n, input int i);
    return (n / mpow(pmod(u), i)) % pmod(u);
  endfunction

  function automatic logic [15:0] pack(input int u, input int n);
    logic [15:0] r = '0;
    for (int i = 0; i < pdig(u); i++) r[4*i +: 4] = 4'(digit_of(u, n, i));
    return r;
  endfunction

  function automatic int clamp_load(input int u, input logic [15:0] lv);
    int n = 0;
    int d;
    for (int i = 0; i < pdig(u); i++) begin
      d = int'(lv[4*i +: 4]);
      if (d >= pmod(u)) d = pmod(u) - 1;
      n += d * mpow(pmod(u), i);
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    for (int u = 0; u < 2; u++) begin
      m_n[u] = 0; m_pre[u] = 0; m_wrap[u] = 1'b0;
      m_sel[u] = 4'd1; m_seg[u] = 7'h3F;
    end
  endtask

  // Advance one unit by one clock edge using the inputs seen at that edge.
  task automatic model_edge(input int u);
    int old, lim, cnt, idx;
    logic [15:0] lv;
    old = m_n[u];
    lim = mpow(pmod(u), pdig(u)) - 1;
    lv  = (u == 0) ? 16'(t_lva) : 16'(t_lvb);
    m_wrap[u] = 1'b0;
    if (t_load) begin
      m_n[u] = clamp_load(u, lv);
      m_pre[u] = 0;
    end else begin
      cnt = m_pre[u] + (t_en ? 1 : 0);
      if (cnt == ptick(u)) begin
        m_pre[u] = 0;
        if (t_dir) begin
          if (old == lim) begin
            if (!t_sat) begin m_n[u] = 0; m_wrap[u] = 1'b1; end
          end else m_n[u] = old + 1;
        end else begin
          if (old == 0) begin
            if (!t_sat) begin m_n[u] = lim; m_wrap[u] = 1'b1; end
          end else m_n[u] = old - 1;
        end
      end else begin
        m_pre[u] = cnt;
      end
    end
    idx = (m_cyc / pscan(u)) % pdig(u);
    m_sel[u] = 4'(1 << idx);
    m_seg[u] = seg_tab[digit_of(u, old, idx)];
  endtask

  task automatic tick();
    @(posedge clk);
    m_cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check("A.value", 16'(ifa.value), pack(0, m_n[0]));
    check("A.wrap",  16'(ifa.wrap_pulse), 16'(m_wrap[0]));
    check("A.sel",   16'(ifa.digit_sel), 16'(m_sel[0]));
    check("A.seg",   16'(ifa.seg), 16'(m_seg[0]));
    check("B.value", 16'(ifb.value), pack(1, m_n[1]));
    check("B.wrap",  16'(ifb.wrap_pulse), 16'(m_wrap[1]));
    check("B.sel",   16'(ifb.digit_sel), 16'(m_sel[1]));
    check("B.seg",   16'(ifb.seg), 16'(m_seg[1]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " A.value"}, 16'(ifa.value), 16'h0);
    check({tag, " A.wrap"},  16'(ifa.wrap_pulse), 16'h0);
    check({tag, " A.sel"},   16'(ifa.digit_sel), 16'h1);
    check({tag, " A.seg"},   16'(ifa.seg), 16'h3F);
    check({tag, " B.value"}, 16'(ifb.value), 16'h0);
    check({tag, " B.sel"},   16'(ifb.digit_sel), 16'h1);
    check({tag, " B.seg"},   16'(ifb.seg), 16'h3F);
  endtask

  // Assert reset between edges, confirm immediate effect, release mid-cycle.
  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst held");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       en, dir, sat;
    logic [7:0] ev;
    logic       ew;
  } vec_a_t;

  typedef struct {
    logic        ld;
    logic [11:0] lv;
    logic        en;
    logic [11:0] ev;
  } vec_b_t;

  vec_a_t tbl_a[$];
  vec_b_t tbl_b[$];

  initial begin
    int wcnt;
    int changes;
    logic [1:0] prev_sel;

    // Config A (mod 10, 2 digits, step every cycle): load clamp, wrap, saturate.
    tbl_a.push_back(vec_a_t'{1'b1, 8'hFA, 1'b1, 1'b1, 1'b0, 8'h99, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 8'h05, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h04, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h99, 1'b1});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h98, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b1, 8'h98, 1'b0, 1'b1, 1'b1, 8'h98, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    tbl_a.push_back(vec_a_t'{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h39, 1'b0});
    tbl_a.push_back(vec_a_t'{1'b1, 8'h37, 1'b0, 1'b1, 1'b0, 8'h37, 1'b0});

    // Config B (mod 6, 3 digits, step every 4 enabled cycles): prescaler hold/restart.
    tbl_b.push_back(vec_b_t'{1'b1, 12'h000, 1'b0, 12'h000});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h000});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h000});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b0, 12'h000});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b0, 12'h000});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h000});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h001});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h001});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h001});
    tbl_b.push_back(vec_b_t'{1'b1, 12'h005, 1'b1, 12'h005});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h005});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h005});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h005});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h010});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h010});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h010});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h010});
    tbl_b.push_back(vec_b_t'{1'b1, 12'h123, 1'b1, 12'h123});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h123});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h123});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h123});
    tbl_b.push_back(vec_b_t'{1'b0, 12'h000, 1'b1, 12'h124});

    model_reset();
    do_reset();

    // Count up from reset through one full wrap.
    t_en = 1'b1; t_dir = 1'b1; t_sat = 1'b0; t_load = 1'b0;
    wcnt = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("up seq", 16'(ifa.value), 16'({4'((k % 100) / 10), 4'(k % 10)}));
      if (ifa.wrap_pulse) wcnt++;
    end
    check("wrap once", 16'(wcnt), 16'd1);

    foreach (tbl_a[i]) begin
      t_load = tbl_a[i].ld; t_lva = tbl_a[i].lv; t_lvb = {4'hE, tbl_a[i].lv};
      t_en = tbl_a[i].en; t_dir = tbl_a[i].dir; t_sat = tbl_a[i].sat;
      tick();
      check("tbl A value", 16'(ifa.value), 16'(tbl_a[i].ev));
      check("tbl A wrap",  16'(ifa.wrap_pulse), 16'(tbl_a[i].ew));
    end

    // Scanner on a held 37: select must toggle every second edge.
    t_load = 1'b0; t_en = 1'b0;
    prev_sel = ifa.digit_sel;
    changes = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ifa.digit_sel != prev_sel) changes++;
      prev_sel = ifa.digit_sel;
    end
    check("scan toggles", 16'(changes), 16'd4);

    t_dir = 1'b1; t_sat = 1'b0; t_lva = 8'h00;
    foreach (tbl_b[i]) begin
      t_load = tbl_b[i].ld; t_lvb = tbl_b[i].lv; t_en = tbl_b[i].en;
      tick();
      check("tbl B value", 16'(ifb.value), 16'(tbl_b[i].ev));
    end

    // Asynchronous reset in the middle of counting, then resume from zero.
    t_load = 1'b0; t_en = 1'b1; t_dir = 1'b1; t_sat = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    do_reset();
    tick();
    check("resume A", 16'(ifa.value), 16'h01);
    check("resume B", 16'(ifb.value), 16'h000);

    // Randomized operation against the model.
    for (int k = 0; k < 1500; k++) begin
      t_en   = ($urandom_range(0, 9) != 0);
      t_sat  = ($urandom_range(0, 3) == 0);
      t_load = ($urandom_range(0, 31) == 0);
      t_lva  = 8'($urandom);
      t_lvb  = 12'($urandom);
      if ($urandom_range(0, 99) == 0) t_dir = ~t_dir;
      if (k == 700) do_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
